nios2_cpu_div_cell: RTL
=======================

// Module: nios2_cpu_div_cell
// PURPOSE
//  Iterative radix-2 restoring divider for the Nios II execute/memory pipeline.
//  It is the inverse-operation companion of the multiply cell: it takes E-stage operands and
//  returns a quotient and remainder after a fixed latency.
//  The start/busy/done handshake lets the pipeline stall for the division's duration.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width in bits (even, >= 4)
// PORTS
//  clk            in   1      rising-edge clock
//  reset_n        in   1      synchronous active-low reset
//  E_src1         in   WIDTH  dividend, sampled on accepted start
//  E_src2         in   WIDTH  divisor, sampled on accepted start
//  E_div_start    in   1      request a division; accepted only in IDLE or DONE
//  E_div_signed   in   1      1 = two's-complement (div), 0 = unsigned (divu); sampled with start
//  M_flush        in   1      pipeline kill: abort any operation and return to IDLE
//  D_div_busy     out  1      high from the cycle after an accepted start until done
//  M_div_done     out  1      one-cycle pulse; results are valid in the same cycle
//  M_div_quot     out  WIDTH  quotient, held until the next accepted start
//  M_div_rem      out  WIDTH  remainder, held until the next accepted start
//  M_div_by_zero  out  1      divisor was zero; held with the results
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE; all outputs 0; iteration counter 0.
//  Reset has priority over flush, and flush has priority over start.
//  States:
//   IDLE  -> PREP on E_div_start.
//   PREP  -> ITER; takes absolute values if signed; records sign(q)=s1^s2 and sign(r)=s1.
//   ITER  -> stays WIDTH cycles, then FIXUP. Each cycle: shift {rem,quo} left 1;
//            trial = rem - divisor (WIDTH+1 bits); if trial >= 0, rem=trial and quo[0]=1.
//   FIXUP -> DONE; negates quo/rem per the recorded signs and applies the special cases.
//   DONE  -> IDLE, or -> PREP if E_div_start is high in this cycle (back-to-back).
//  Latency: M_div_done is high exactly WIDTH+3 cycles after the cycle in which start is
//   accepted (35 for WIDTH=32). Latency is fixed; there is no early termination.
//  D_div_busy is high in PREP, ITER and FIXUP, and low in IDLE and DONE.
//  Start in PREP/ITER/FIXUP is ignored; no queueing.
//  Divide by zero: quot=all-ones, rem=dividend (original, unsigned/signed as given),
//   M_div_by_zero=1. The latency is unchanged.
//  Signed overflow (-2^(WIDTH-1) / -1): quot=-2^(WIDTH-1) (0x80000000), rem=0.
//  Remainder sign follows the dividend; the quotient truncates toward zero.
//  M_flush in any state: next state is IDLE and done stays low. Result outputs keep their
//   previous values. M_div_done never pulses for a flushed operation.
//  Operands are captured at start; later changes to E_src1/E_src2 have no effect.
//  Internal datapath: WIDTH-bit rem register, WIDTH-bit quo register,
//   WIDTH+1-bit subtractor, ceil(log2(WIDTH))+1-bit counter.
// STRUCTURE
//  Shared package (nios2_cpu_pkg): div state encoding localparams
//   (IDLE/PREP/ITER/FIXUP/DONE), DIV_WIDTH default.
//  One sub-module: nios2_cpu_div_step. It is combinational and performs one restoring
//   iteration: (rem_in, quo_in, divisor) -> (rem_out, quo_out).
//   It is instantiated once; the parent holds the state machine, counter and sign fixup.
// TESTING
//  1 unsigned 100/7, start 1 cycle -> done at +35, quot=14, rem=2, by_zero=0, busy 34 cycles
//  2 signed -7/2 (0xFFFFFFF9, 2) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; 7/-2 -> quot=-3, rem=1
//  3 divisor 0, dividend 0x1234 unsigned -> done at +35, quot=0xFFFFFFFF, rem=0x1234, by_zero=1
//  4 signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned 0xFFFFFFFF/1 -> quot=0xFFFFFFFF
//  5 start, M_flush at +10 -> IDLE next cycle, no done pulse, outputs unchanged; new start ok
//  6 start held high during busy -> single result; reset_n low at +20 -> all outputs 0, IDLE

Source files
------------

// File: rtl/nios2_cpu_pkg.sv
// Shared Nios II CPU definitions used by the divider cell: state encoding and default width.
package nios2_cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_PREP  = 3'd1,
    DIV_ITER  = 3'd2,
    DIV_FIXUP = 3'd3,
    DIV_DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/nios2_cpu_div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module nios2_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           fits;

  // rem_in < divisor, so rem_sh < 2*divisor and the top bit of trial is a valid sign bit.
  assign rem_sh  = {rem_in, quo_in[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, divisor};
  assign fits    = ~trial[WIDTH];
  assign rem_out = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/nios2_cpu_div_cell.sv
// Iterative radix-2 restoring divider (div/divu) with start/busy/done handshake and flush.
module nios2_cpu_div_cell
  import nios2_cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic             M_flush,
  output logic             D_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_by_zero,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: E_div_start is accepted when the cell is IDLE or DONE and no flush is present;
  // D_div_busy covers PREP..FIXUP and M_div_done is a one-cycle pulse with results valid.
  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic             sgn_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0] quot_r, rem_r;
  logic             byz_r;
  logic             start_ok;
  logic             last_iter;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic             div_zero;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign start_ok  = E_div_start && !M_flush && (state_q == DIV_IDLE || state_q == DIV_DONE);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:  if (E_div_start) state_d = DIV_PREP;
      DIV_PREP:  state_d = DIV_ITER;
      DIV_ITER:  if (last_iter) state_d = DIV_FIXUP;
      DIV_FIXUP: state_d = DIV_DONE;
      DIV_DONE:  state_d = E_div_start ? DIV_PREP : DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
    if (M_flush) state_d = DIV_IDLE;
  end

  assign abs1 = (sgn_q && src1_q[WIDTH-1]) ? -src1_q : src1_q;
  assign abs2 = (sgn_q && src2_q[WIDTH-1]) ? -src2_q : src2_q;

  nios2_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // The overflow case (-2^(W-1) / -1) falls out naturally: |a|/1 = 2^(W-1) with no negation.
  assign div_zero = (src2_q == '0);
  assign quot_fix = div_zero ? '1     : (neg_quo_q ? -quo_q : quo_q);
  assign rem_fix  = div_zero ? src1_q : (neg_rem_q ? -rem_q : rem_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quot_r    <= '0;
      rem_r     <= '0;
      byz_r     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        src1_q <= E_src1;
        src2_q <= E_src2;
        sgn_q  <= E_div_signed;
      end
      case (state_q)
        DIV_PREP: begin
          rem_q     <= '0;
          quo_q     <= abs1;
          dvs_q     <= abs2;
          neg_quo_q <= sgn_q && (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
          neg_rem_q <= sgn_q && src1_q[WIDTH-1];
          cnt_q     <= '0;
        end
        DIV_ITER: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
        end
        DIV_FIXUP: begin
          if (!M_flush) begin
            quot_r <= quot_fix;
            rem_r  <= rem_fix;
            byz_r  <= div_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign D_div_busy    = (state_q == DIV_PREP) || (state_q == DIV_ITER) || (state_q == DIV_FIXUP);
  assign M_div_done    = (state_q == DIV_DONE);
  assign M_div_quot    = quot_r;
  assign M_div_rem     = rem_r;
  assign M_div_by_zero = byz_r;
  assign dbg_state     = state_q;

endmodule
